baud_detect: RTL and testbench
==============================

Name: baud_detect

Overview:
- Auto-baud detector, the measuring counterpart to the baud tick generator.
- Once armed, it times the low pulse of an incoming start bit on the serial rx line and classifies the pulse width into one of the four supported baud codes.
- The resulting 2-bit code drives the generator's bd_rate select, so the UART locks to the remote rate without software configuration.

Parameters:
- CNT_W, default defs::baud_calc: width of the pulse-width counter.
- TICK_0, default defs::baud_tick_1: clk cycles per bit for code 0.
- TICK_1, default defs::baud_tick_2: clk cycles per bit for code 1.
- TICK_2, default defs::baud_tick_3: clk cycles per bit for code 2.
- TICK_3, default defs::baud_tick_4: clk cycles per bit for code 3.
- TOL_SH, default 3: match tolerance is TICK_i >> TOL_SH, i.e. ±12.5%.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- arm  in  1  single-cycle pulse; starts or restarts detection.
- rx  in  1  raw serial line, asynchronous, idle high.
- bd_rate  out  2  detected baud code, valid while locked=1.
- locked  out  1  high once a valid rate has been detected; cleared by arm.
- done  out  1  one-cycle pulse when a classification succeeds.
- err  out  1  one-cycle pulse when a measured pulse matches no code or overflows.

Interface note (already decided): one clock; reset is asynchronous and active-high.

Behaviour:
Reset:
- Asynchronous.
- Values: bd_rate=0, locked=0, done=0, err=0, state=IDLE, synchronizer flops=1, counter=0.

Input synchronization:
- rx passes through a 2-flop synchronizer to give rx_s.
- All timing below refers to rx_s, so there is a 2-cycle input latency.

States:
- IDLE: ignore rx. arm → WAIT_HIGH.
- WAIT_HIGH: wait for rx_s=1, so a line already low is never mis-measured. rx_s=1 → WAIT_FALL.
- WAIT_FALL: rx_s=0 → MEASURE, with counter loaded to 1.
- MEASURE: counter increments each cycle while rx_s=0. rx_s=1 → CLASSIFY, with counter holding the number of low cycles.
- CLASSIFY (1 cycle):
  - Code i matches if |cnt − TICK_i| ≤ (TICK_i >> TOL_SH).
  - If several codes match, the lowest index wins.
  - Match: bd_rate=i, locked=1, done pulse, → IDLE.
  - No match: err pulse, bd_rate and locked unchanged, → WAIT_FALL (still armed, retries on the next start bit).

Overflow:
- In MEASURE, when cnt reaches LIMIT+1, where LIMIT = TICK_3 + (TICK_3 >> TOL_SH), raise an err pulse that cycle and go → WAIT_HIGH.
- The counter never wraps.
- TICK_0 < TICK_1 < TICK_2 < TICK_3 is required, and CNT_W must hold LIMIT+1.

arm handling:
- arm in any state clears locked, zeroes the counter and forces WAIT_HIGH next cycle.
- An in-flight measurement is abandoned without an err pulse.
- arm takes priority over a simultaneous CLASSIFY result: no done or err pulse is produced.

Output properties:
- done and err are never high together.
- Each pulse lasts exactly one cycle.
- Tolerance arithmetic is unsigned and sized to CNT_W+1 bits to avoid underflow.
- reset asserted mid-measurement returns all outputs to their reset values immediately.

Decomposition:
- The defs package already holds baud_calc and baud_tick_1..4.
- Add to defs:
  - enum typedef bd_state_t {IDLE, WAIT_HIGH, WAIT_FALL, MEASURE, CLASSIFY};
  - localparam BAUD_TOL_SH = 3.
- Sub-module sync2: a generic 2-flop synchronizer with async active-high reset and reset value 1. It is reusable by the UART receiver.
- Classification stays inline as combinational logic.

Test Plan (bench overrides TICK_0..3 = 16, 32, 64, 128; match windows 14–18, 28–36, 56–72, 112–144; LIMIT = 144):
- arm, idle high, then a 32-cycle low pulse → done pulse 2 cycles after the rising edge plus the CLASSIFY cycle; bd_rate=1, locked=1.
- Pulses of 14, then 144 (re-arm between) → bd_rate=0, then bd_rate=3 (window boundaries inclusive).
- arm, low pulse of 24 → err pulse, locked=0; next low pulse of 64 with no re-arm → done, bd_rate=2.
- arm, rx held low for 200 cycles → single err pulse at cnt=145, no done; after rx rises and a 16-cycle low pulse → bd_rate=0.
- arm while rx already low, rising after 40 cycles, then a 128-cycle low pulse → the first pulse is ignored (no done/err); the second gives bd_rate=3.
- Lock at bd_rate=2, then assert reset mid-way through a second measurement → bd_rate=0, locked=0, no pulses; after release no activity until arm.

Source files
------------

// File: rtl/baud_detect_pkg.sv
// rtl/baud_detect_pkg.sv - shared constants and types for the auto-baud detector
//
// Purpose: default counter width, per-code bit periods (clk cycles per bit,
// ascending so code 0 is the fastest rate), tolerance shift and the FSM
// state type used by baud_detect.
// Ports: none (package).

package baud_detect_pkg;

  // Bit periods at a 50 MHz clock: 115200, 57600, 19200, 9600 baud.
  localparam int baud_tick_1 = 434;
  localparam int baud_tick_2 = 868;
  localparam int baud_tick_3 = 2604;
  localparam int baud_tick_4 = 5208;

  // Must hold baud_tick_4 + (baud_tick_4 >> BAUD_TOL_SH) + 1 = 5860.
  localparam int baud_calc   = 13;

  // Window half-width is tick >> 3, i.e. +/-12.5 %.
  localparam int BAUD_TOL_SH = 3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HIGH,
    WAIT_FALL,
    MEASURE,
    CLASSIFY
  } bd_state_t;

endpackage

// File: rtl/baud_detect_if.sv
// rtl/baud_detect_if.sv - control/result bundle between a host and baud_detect
//
// Purpose: groups the arm request, the raw rx line and the detection results.
// Signals:
//   arm     host -> detector, one-cycle pulse starting/restarting detection
//   rx      line -> detector, raw asynchronous serial input, idle high
//   bd_rate detector -> host, detected baud code, valid while locked=1
//   locked  detector -> host, a rate has been detected since the last arm
//   done    detector -> host, one-cycle pulse on successful classification
//   err     detector -> host, one-cycle pulse on unmatched or overlong pulse
// Modports: master (host side), slave (detector side).

interface baud_detect_if;
  logic       arm;
  logic       rx;
  logic [1:0] bd_rate;
  logic       locked;
  logic       done;
  logic       err;

  modport master (
    output arm,
    output rx,
    input  bd_rate,
    input  locked,
    input  done,
    input  err
  );

  modport slave (
    input  arm,
    input  rx,
    output bd_rate,
    output locked,
    output done,
    output err
  );
endinterface

// File: rtl/baud_detect_sync2.sv
// rtl/baud_detect_sync2.sv - generic two-flop synchronizer, resets to 1
//
// Purpose: brings an asynchronous level into the i_clk domain. Reset value is
// 1 so an idle-high serial line looks idle straight out of reset.
// Ports:
//   i_clk  clock
//   i_rst  asynchronous active-high reset
//   i_d    asynchronous input
//   o_q    synchronized output (2-cycle latency)

module sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/baud_detect.sv
// rtl/baud_detect.sv - auto-baud detector timing the low pulse of a start bit
//
// Purpose: once armed, waits for an idle-high line, times the next low pulse
// on the synchronized rx and maps its width to one of four baud codes.
// Ports:
//   i_clk   system clock
//   i_rst   asynchronous active-high reset
//   io_bus  baud_detect_if.slave: arm, rx in; bd_rate, locked, done, err out

module baud_detect
  import baud_detect_pkg::*;
#(
  parameter int CNT_W  = baud_calc,
  parameter int TICK_0 = baud_tick_1,
  parameter int TICK_1 = baud_tick_2,
  parameter int TICK_2 = baud_tick_3,
  parameter int TICK_3 = baud_tick_4,
  parameter int TOL_SH = BAUD_TOL_SH
) (
  input  logic          i_clk,
  input  logic          i_rst,
  baud_detect_if.slave  io_bus
);

  // Longest pulse that can still match code 3; one more cycle is an overflow.
  localparam int               LIMIT   = TICK_3 + (TICK_3 >> TOL_SH);
  localparam logic [CNT_W-1:0] CNT_OVF = CNT_W'(LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  bd_state_t        r_state;
  bd_state_t        w_next;
  logic             w_rx_s;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_bd_rate;
  logic             r_locked;
  logic [3:0]       w_hit;
  logic             w_match;
  logic [1:0]       w_code;
  logic             w_ovf;
  logic             w_done;
  logic             w_err;

  sync2 u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (io_bus.rx),
    .o_q   (w_rx_s)
  );

  // |cnt - tick| <= tick >> TOL_SH, done one bit wider than the counter so
  // neither the subtraction nor the tick constant can wrap.
  function automatic logic in_window(input logic [CNT_W-1:0] cnt, input int tick);
    logic [CNT_W:0] c;
    logic [CNT_W:0] t;
    logic [CNT_W:0] d;
    c = {1'b0, cnt};
    t = (CNT_W+1)'(tick);
    d = (c >= t) ? (c - t) : (t - c);
    return d <= (t >> TOL_SH);
  endfunction

  assign w_hit = {in_window(r_cnt, TICK_3), in_window(r_cnt, TICK_2),
                  in_window(r_cnt, TICK_1), in_window(r_cnt, TICK_0)};
  assign w_match = |w_hit;

  // Walk downwards so the lowest matching index is the last one written.
  always_comb begin
    w_code = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_hit[i]) w_code = 2'(i);
    end
  end

  assign w_ovf = (r_state == MEASURE) && (r_cnt == CNT_OVF);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; arm overrides everything, including CLASSIFY.
  always_comb begin
    w_next = r_state;
    if (io_bus.arm) begin
      w_next = WAIT_HIGH;
    end else begin
      case (r_state)
        IDLE:      w_next = IDLE;
        WAIT_HIGH: if (w_rx_s)  w_next = WAIT_FALL;
        WAIT_FALL: if (!w_rx_s) w_next = MEASURE;
        MEASURE: begin
          // Overflow wins even if the line rises in the same cycle.
          if (w_ovf)       w_next = WAIT_HIGH;
          else if (w_rx_s) w_next = CLASSIFY;
        end
        CLASSIFY:  w_next = w_match ? IDLE : WAIT_FALL;
        default:   w_next = IDLE;
      endcase
    end
  end

  // Output pulses, suppressed whenever arm is present.
  always_comb begin
    w_done = 1'b0;
    w_err  = 1'b0;
    if (!io_bus.arm) begin
      if (r_state == CLASSIFY) begin
        w_done = w_match;
        w_err  = !w_match;
      end else if (w_ovf) begin
        w_err  = 1'b1;
      end
    end
  end

  // Pulse-width counter and result registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_bd_rate <= 2'd0;
      r_locked  <= 1'b0;
    end else if (io_bus.arm) begin
      r_cnt     <= '0;
      r_locked  <= 1'b0;
    end else begin
      // The falling edge is seen in WAIT_FALL, so that cycle already counts.
      if (r_state == WAIT_FALL && !w_rx_s) begin
        r_cnt <= CNT_ONE;
      end else if (r_state == MEASURE && !w_rx_s && !w_ovf) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      if (w_done) begin
        r_bd_rate <= w_code;
        r_locked  <= 1'b1;
      end
    end
  end

  assign io_bus.bd_rate = r_bd_rate;
  assign io_bus.locked  = r_locked;
  assign io_bus.done    = w_done;
  assign io_bus.err     = w_err;

endmodule

// File: tb/tb_baud_detect.sv
// tb/tb_baud_detect.sv - scoreboard bench for baud_detect

module tb_baud_detect;

  localparam int LIMIT = 144;

  typedef struct {
    bit is_done;
    int code;
    int rate;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t sb[$];
  bit   armed = 1'b0;
  int   model_rate = 0;

  baud_detect_if bus ();

  baud_detect #(
    .CNT_W  (8),
    .TICK_0 (16),
    .TICK_1 (32),
    .TICK_2 (64),
    .TICK_3 (128),
    .TOL_SH (3)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference rule: first code whose nominal period is within 1/8 of itself.
  function automatic int classify(int n);
    int ticks[4];
    int d;
    ticks = '{16, 32, 64, 128};
    for (int i = 0; i < 4; i++) begin
      d = (n > ticks[i]) ? n - ticks[i] : ticks[i] - n;
      if (d <= ticks[i] / 8) return i;
    end
    return -1;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push(bit is_done, int code, int at);
    exp_t e;
    e.is_done = is_done;
    e.code    = code;
    e.rate    = is_done ? code : model_rate;
    e.cyc     = at;
    sb.push_back(e);
  endtask

  task automatic do_arm;
    step;
    bus.arm = 1'b1;
    step;
    bus.arm = 1'b0;
    armed = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL arm_clears_locked: locked=%0b want 0", bus.locked);
    end
  endtask

  // Low pulse of n cycles followed by gap idle cycles.
  task automatic pulse(int n, int gap);
    int f;
    int c;
    step;
    bus.rx = 1'b0;
    f = cyc;
    if (armed) begin
      c = classify(n);
      if (n > LIMIT) begin
        push(1'b0, 0, f + LIMIT + 3);
      end else if (c >= 0) begin
        push(1'b1, c, f + n + 3);
        model_rate = c;
        armed = 1'b0;
      end else begin
        push(1'b0, 0, f + n + 3);
      end
    end
    repeat (n) step;
    bus.rx = 1'b1;
    repeat (gap) step;
  endtask

  // Monitor: pops expectations whenever the DUT pulses done or err.
  bit post_chk = 1'b0;
  int post_rate;
  bit post_locked;
  always @(negedge clk) begin
    if (rst) begin
      post_chk = 1'b0;
    end else begin
      if (post_chk) begin
        checks++;
        if (bus.bd_rate !== 2'(post_rate) || bus.locked !== post_locked ||
            bus.done !== 1'b0 || bus.err !== 1'b0) begin
          errors++;
          $display("FAIL after_pulse: bd_rate=%0d locked=%0b done=%0b err=%0b want %0d %0b 0 0",
                   bus.bd_rate, bus.locked, bus.done, bus.err, post_rate, post_locked);
        end
        post_chk = 1'b0;
      end
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_pulse: done=%0b expected at cycle %0d, not observed",
                 sb[0].is_done, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (bus.done === 1'b1 || bus.err === 1'b1) begin
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: done=%0b err=%0b at cycle %0d, want none",
                   bus.done, bus.err, cyc);
        end else begin
          e = sb.pop_front();
          if (bus.done !== e.is_done || bus.err !== !e.is_done || e.cyc != cyc) begin
            errors++;
            $display("FAIL pulse: done=%0b err=%0b cycle=%0d want done=%0b err=%0b cycle=%0d",
                     bus.done, bus.err, cyc, e.is_done, !e.is_done, e.cyc);
          end
          post_chk    = 1'b1;
          post_rate   = e.rate;
          post_locked = e.is_done;
        end
      end
    end
  end

  int edges[16] = '{13, 14, 18, 19, 27, 28, 36, 37, 55, 56, 72, 73, 111, 112, 144, 145};

  initial begin
    bus.arm = 1'b0;
    bus.rx  = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.bd_rate !== 2'd0 || bus.locked !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: bd_rate=%0d locked=%0b done=%0b err=%0b want 0 0 0 0",
               bus.bd_rate, bus.locked, bus.done, bus.err);
    end
    repeat (3) step;
    rst = 1'b0;
    repeat (4) step;

    // Basic lock on code 1.
    do_arm; pulse(32, 8);
    // Inclusive window edges.
    do_arm; pulse(14, 8);
    do_arm; pulse(144, 8);
    // Unmatched pulse then retry without re-arm.
    do_arm; pulse(24, 8); pulse(64, 8);
    // Overflow then retry.
    do_arm; pulse(200, 8); pulse(16, 8);
    // Arm while the line is already low: that pulse is ignored.
    step;
    bus.rx = 1'b0;
    repeat (5) step;
    bus.arm = 1'b1;
    step;
    bus.arm = 1'b0;
    armed = 1'b1;
    repeat (35) step;
    bus.rx = 1'b1;
    repeat (6) step;
    pulse(128, 8);
    // Arm landing on the classification cycle suppresses done.
    do_arm;
    step;
    bus.rx = 1'b0;
    repeat (32) step;
    bus.rx = 1'b1;
    repeat (3) step;
    bus.arm = 1'b1;
    step;
    bus.arm = 1'b0;
    armed = 1'b1;
    repeat (6) step;
    pulse(16, 8);

    // Randomized pulses with boundary-heavy widths.
    for (int k = 0; k < 40; k++) begin
      int n;
      if ($urandom_range(0, 1) == 1) n = edges[$urandom_range(0, 15)];
      else                           n = int'($urandom_range(8, 170));
      if ($urandom_range(0, 1) == 1) do_arm;
      pulse(n, int'($urandom_range(5, 12)));
    end

    // Lock at code 2, then reset in the middle of the next measurement.
    do_arm; pulse(64, 8);
    do_arm;
    step;
    bus.rx = 1'b0;
    repeat (30) step;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.bd_rate !== 2'd0 || bus.locked !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: bd_rate=%0d locked=%0b done=%0b err=%0b want 0 0 0 0",
               bus.bd_rate, bus.locked, bus.done, bus.err);
    end
    model_rate = 0;
    armed = 1'b0;
    repeat (3) step;
    bus.rx = 1'b1;
    step;
    rst = 1'b0;
    repeat (5) step;
    pulse(32, 8);
    @(negedge clk);
    checks++;
    if (bus.locked !== 1'b0 || bus.bd_rate !== 2'd0) begin
      errors++;
      $display("FAIL idle_after_reset: locked=%0b bd_rate=%0d want 0 0", bus.locked, bus.bd_rate);
    end

    repeat (200) step;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected pulses never observed, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
